// File: rtl/fifo_pkg.sv
// Shared register map, STATUS/CTRL bit positions and CTRL layout for the stream bridge.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package fifo_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_LEVEL  = 2'd3;

    localparam int ST_RX_EMPTY    = 0;
    localparam int ST_RX_FULL     = 1;
    localparam int ST_TX_EMPTY    = 2;
    localparam int ST_TX_FULL     = 3;
    localparam int ST_RX_UNDERRUN = 4;
    localparam int ST_TX_OVERFLOW = 5;

    localparam int CT_RX_IRQ_EN  = 0;
    localparam int CT_TX_IRQ_EN  = 1;
    localparam int CT_RX_FLUSH   = 2;
    localparam int CT_TX_FLUSH   = 3;
    localparam int CT_THRESH_LSB = 8;

    typedef struct packed {
        logic [7:0] rx_thresh;
        logic       tx_irq_en;
        logic       rx_irq_en;
    } ctrl_t;

    // A zero threshold would fire permanently on an empty FIFO, so it acts as 1.
    function automatic logic [7:0] eff_thresh(input logic [7:0] t);
        return (t == 8'd0) ? 8'd1 : t;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with fall-through head, occupancy count and synchronous flush.
// Latency: push visible at head one cycle after the push edge; count updates at the same edge.
// Backpressure: push ignored when full, pop ignored when empty; flush overrides both.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    // Storage is never reset, so the head is masked to keep it defined while empty.
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/fifo_mmio_bridge.sv
// MMIO bridge: CPU DATA/STATUS/CTRL/LEVEL registers over a TX FIFO to in_* and an RX FIFO from out_*.
// Latency: bus read data combinational; pushes, pops and register writes land at the next edge; IRQs one cycle later.
// Backpressure: out_ready_o drops when RX is full; in_valid_o low when TX empty; CPU overflow/underrun are dropped and flagged.
module fifo_mmio_bridge
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              sel_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [1:0]        addr_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              rx_irq_o,
    output logic              tx_irq_o,
    output logic [DATA_W-1:0] in_data_o,
    output logic              in_valid_o,
    input  logic              in_ready_i,
    input  logic [DATA_W-1:0] out_data_i,
    input  logic              out_valid_i,
    output logic              out_ready_o
);

    localparam int TXCW = $clog2(TX_DEPTH) + 1;
    localparam int RXCW = $clog2(RX_DEPTH) + 1;

    ctrl_t             ctrl;
    logic              rx_underrun;
    logic              tx_overflow;

    logic [TXCW-1:0]   tx_count;
    logic [RXCW-1:0]   rx_count;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [DATA_W-1:0] rx_head;
    logic [15:0]       tx_level, rx_level;

    logic              data_rd, data_wr, status_wr, ctrl_wr;
    logic              rx_flush, tx_flush;
    logic [31:0]       status_word, ctrl_word;
    logic              unused_data;

    assign data_rd   = sel_i & read_i  & (addr_i == REG_DATA);
    assign data_wr   = sel_i & write_i & (addr_i == REG_DATA);
    assign status_wr = sel_i & write_i & (addr_i == REG_STATUS);
    assign ctrl_wr   = sel_i & write_i & (addr_i == REG_CTRL);
    assign rx_flush  = ctrl_wr & data_i[CT_RX_FLUSH];
    assign tx_flush  = ctrl_wr & data_i[CT_TX_FLUSH];
    assign unused_data = ^data_i;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .push     (data_wr),
        .push_dat (data_i[DATA_W-1:0]),
        .pop      (in_ready_i),
        .flush    (tx_flush),
        .head_dat (in_data_o),
        .count    (tx_count),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .push     (out_valid_i),
        .push_dat (out_data_i),
        .pop      (data_rd),
        .flush    (rx_flush),
        .head_dat (rx_head),
        .count    (rx_count),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    assign in_valid_o  = ~tx_empty;
    assign out_ready_o = ~rx_full;
    assign tx_level    = 16'(tx_count);
    assign rx_level    = 16'(rx_count);

    always_comb begin
        status_word                 = '0;
        status_word[ST_RX_EMPTY]    = rx_empty;
        status_word[ST_RX_FULL]     = rx_full;
        status_word[ST_TX_EMPTY]    = tx_empty;
        status_word[ST_TX_FULL]     = tx_full;
        status_word[ST_RX_UNDERRUN] = rx_underrun;
        status_word[ST_TX_OVERFLOW] = tx_overflow;

        ctrl_word                            = '0;
        ctrl_word[CT_RX_IRQ_EN]              = ctrl.rx_irq_en;
        ctrl_word[CT_TX_IRQ_EN]              = ctrl.tx_irq_en;
        ctrl_word[CT_THRESH_LSB +: 8]        = ctrl.rx_thresh;
    end

    // Decoded on addr_i alone so data_o stays defined even when not selected.
    always_comb begin
        data_o = '0;
        case (addr_i)
            REG_DATA:   data_o = 32'(rx_head);
            REG_STATUS: data_o = status_word;
            REG_CTRL:   data_o = ctrl_word;
            REG_LEVEL:  data_o = {tx_level, rx_level};
            default:    data_o = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ctrl        <= '0;
            rx_underrun <= 1'b0;
            tx_overflow <= 1'b0;
            rx_irq_o    <= 1'b0;
            tx_irq_o    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ctrl.rx_irq_en <= data_i[CT_RX_IRQ_EN];
                ctrl.tx_irq_en <= data_i[CT_TX_IRQ_EN];
                ctrl.rx_thresh <= data_i[CT_THRESH_LSB +: 8];
            end

            if (data_rd && rx_empty)
                rx_underrun <= 1'b1;
            else if (status_wr && data_i[ST_RX_UNDERRUN])
                rx_underrun <= 1'b0;

            if (data_wr && tx_full)
                tx_overflow <= 1'b1;
            else if (status_wr && data_i[ST_TX_OVERFLOW])
                tx_overflow <= 1'b0;

            rx_irq_o <= ctrl.rx_irq_en & (rx_level >= 16'(eff_thresh(ctrl.rx_thresh)));
            tx_irq_o <= ctrl.tx_irq_en & tx_empty;
        end
    end

endmodule

// File: tb/tb_fifo_mmio_bridge.sv
// Bench for fifo_mmio_bridge: queue-level reference model checked every cycle plus directed literal checks.
module tb_fifo_mmio_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic        sel, rd, wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rx_irq, tx_irq;
    logic [7:0]  in_data;
    logic        in_valid, in_ready;
    logic [7:0]  out_data;
    logic        out_valid, out_ready;

    int total = 0;
    int passed = 0;

    fifo_mmio_bridge #(.DATA_W(8), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .sel_i      (sel),
        .read_i     (rd),
        .write_i    (wr),
        .addr_i     (addr),
        .data_i     (wdata),
        .data_o     (rdata),
        .rx_irq_o   (rx_irq),
        .tx_irq_o   (tx_irq),
        .in_data_o  (in_data),
        .in_valid_o (in_valid),
        .in_ready_i (in_ready),
        .out_data_i (out_data),
        .out_valid_i(out_valid),
        .out_ready_o(out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit m_rx_en, m_tx_en, m_und, m_ovf, m_rx_irq, m_tx_irq;
    int m_thresh;
    bit n_rx_irq, n_tx_irq, cpu_rd, cpu_wr, tx_pop, tx_push, rx_push, rx_pop;

    function automatic logic [31:0] m_rdata(input logic [1:0] a);
        logic [31:0] v;
        v = 32'h0;
        case (a)
            2'd0: if (rx_q.size() != 0) v = {24'h0, rx_q[0]};
            2'd1: v = {26'h0, m_ovf, m_und, tx_q.size() == 16, tx_q.size() == 0,
                       rx_q.size() == 16, rx_q.size() == 0};
            2'd2: v = {16'h0, 8'(m_thresh), 6'h0, m_tx_en, m_rx_en};
            default: v = {16'(tx_q.size()), 16'(rx_q.size())};
        endcase
        return v;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_q.delete(); rx_q.delete();
            m_rx_en = 0; m_tx_en = 0; m_und = 0; m_ovf = 0;
            m_rx_irq = 0; m_tx_irq = 0; m_thresh = 0;
        end else begin
            n_rx_irq = m_rx_en && (rx_q.size() >= ((m_thresh == 0) ? 1 : m_thresh));
            n_tx_irq = m_tx_en && (tx_q.size() == 0);
            cpu_rd  = sel && rd && addr == 2'd0;
            cpu_wr  = sel && wr && addr == 2'd0;
            tx_pop  = in_ready && tx_q.size() != 0;
            tx_push = cpu_wr && tx_q.size() < 16;
            rx_pop  = cpu_rd && rx_q.size() != 0;
            rx_push = out_valid && rx_q.size() < 16;
            if (cpu_rd && rx_q.size() == 0) m_und = 1;
            if (cpu_wr && tx_q.size() == 16) m_ovf = 1;
            if (sel && wr && addr == 2'd1) begin
                if (wdata[4]) m_und = 0;
                if (wdata[5]) m_ovf = 0;
            end
            if (sel && wr && addr == 2'd2 && wdata[3]) tx_q.delete();
            else begin
                if (tx_pop) void'(tx_q.pop_front());
                if (tx_push) tx_q.push_back(wdata[7:0]);
            end
            if (sel && wr && addr == 2'd2 && wdata[2]) rx_q.delete();
            else begin
                if (rx_pop) void'(rx_q.pop_front());
                if (rx_push) rx_q.push_back(out_data);
            end
            if (sel && wr && addr == 2'd2) begin
                m_rx_en = wdata[0]; m_tx_en = wdata[1]; m_thresh = int'(wdata[15:8]);
            end
            m_rx_irq = n_rx_irq;
            m_tx_irq = n_tx_irq;
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            chk("cyc_in_valid", 32'(in_valid), 32'(tx_q.size() != 0));
            if (tx_q.size() != 0) chk("cyc_in_data", 32'(in_data), 32'(tx_q[0]));
            chk("cyc_out_ready", 32'(out_ready), 32'(rx_q.size() < 16));
            chk("cyc_rx_irq", 32'(rx_irq), 32'(m_rx_irq));
            chk("cyc_tx_irq", 32'(tx_irq), 32'(m_tx_irq));
            if (sel) chk("cyc_data_o", rdata, m_rdata(addr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        sel = 1; wr = 1; addr = a; wdata = d;
        tick();
        sel = 0; wr = 0; wdata = 32'h0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        sel = 1; rd = 1; addr = a;
        #2 d = rdata;
        tick();
        sel = 0; rd = 0;
    endtask

    logic [31:0] v;

    initial begin
        rstn = 0; sel = 0; rd = 0; wr = 0; addr = 2'd0; wdata = 32'h0;
        in_ready = 0; out_data = 8'h0; out_valid = 0;
        #12;
        chk("rst_rx_irq", 32'(rx_irq), 32'h0);
        chk("rst_tx_irq", 32'(tx_irq), 32'h0);
        chk("rst_in_valid", 32'(in_valid), 32'h0);
        chk("rst_out_ready", 32'(out_ready), 32'h1);
        chk("rst_in_data", 32'(in_data), 32'h0);
        rstn = 1;
        tick();

        bus_read(2'd1, v); chk("status_after_reset", v, 32'h5);

        // TX stream ordering
        bus_write(2'd0, 32'hA1); bus_write(2'd0, 32'hB2); bus_write(2'd0, 32'hC3);
        bus_read(2'd3, v); chk("level_tx3", v, 32'h0003_0000);
        in_ready = 1;
        #2 chk("stream_a1", 32'(in_data), 32'hA1);
        tick(); #2 chk("stream_b2", 32'(in_data), 32'hB2);
        tick(); #2 chk("stream_c3", 32'(in_data), 32'hC3);
        tick(); #2 chk("stream_done", 32'(in_valid), 32'h0);
        in_ready = 0;
        tick();

        // RX fill to full
        for (int i = 0; i < 16; i++) begin
            out_valid = 1; out_data = 8'(8'h10 + i);
            tick();
        end
        out_valid = 0;
        #2 chk("rx_full_ready", 32'(out_ready), 32'h0);
        tick();
        bus_read(2'd1, v); chk("status_rx_full", v, 32'h6);
        bus_read(2'd0, v); chk("rx_first_byte", v, 32'h10);
        #2 chk("ready_after_pop", 32'(out_ready), 32'h1);
        tick();
        bus_write(2'd2, 32'h4);
        bus_read(2'd3, v); chk("level_after_rx_flush", v, 32'h0);

        // TX overflow
        for (int i = 0; i < 17; i++) bus_write(2'd0, 32'(8'h40 + i));
        bus_read(2'd1, v); chk("status_overflow", v, 32'h29);
        bus_read(2'd3, v); chk("level_tx_full", v, 32'h0010_0000);
        bus_write(2'd1, 32'h20);
        bus_read(2'd1, v); chk("status_ovf_cleared", v, 32'h09);
        in_ready = 1;
        for (int i = 0; i < 16; i++) begin
            #2 chk("drain_byte", 32'(in_data), 32'(8'h40 + i));
            tick();
        end
        #2 chk("drain_empty", 32'(in_valid), 32'h0);
        in_ready = 0;
        tick();

        // RX threshold interrupt
        bus_write(2'd2, 32'h0401);
        for (int i = 0; i < 3; i++) begin
            out_valid = 1; out_data = 8'(8'h50 + i);
            tick();
        end
        out_valid = 0;
        tick(); #2 chk("rx_irq_at3", 32'(rx_irq), 32'h0);
        tick();
        out_valid = 1; out_data = 8'h53;
        tick();
        out_valid = 0;
        #2 chk("rx_irq_lag", 32'(rx_irq), 32'h0);
        tick(); #2 chk("rx_irq_at4", 32'(rx_irq), 32'h1);
        tick();
        bus_read(2'd0, v); chk("rx_irq_pop_byte", v, 32'h50);
        tick(); #2 chk("rx_irq_after_pop", 32'(rx_irq), 32'h0);
        tick();

        // TX flush racing a stream pop
        bus_write(2'd2, 32'h6);
        tick(); #2 chk("tx_irq_empty", 32'(tx_irq), 32'h1);
        tick();
        for (int i = 0; i < 5; i++) bus_write(2'd0, 32'(8'h60 + i));
        #2 chk("tx_irq_filled", 32'(tx_irq), 32'h0);
        tick();
        bus_read(2'd3, v); chk("level_tx5", v, 32'h0005_0000);
        in_ready = 1;
        bus_write(2'd2, 32'hA);
        in_ready = 0;
        #2 chk("flush_in_valid", 32'(in_valid), 32'h0);
        tick(); #2 chk("flush_tx_irq", 32'(tx_irq), 32'h1);
        tick();
        bus_read(2'd3, v); chk("level_after_flush", v, 32'h0);
        bus_read(2'd0, v); chk("underrun_data", v, 32'h0);
        bus_read(2'd1, v); chk("status_underrun", v, 32'h15);
        bus_read(2'd2, v); chk("ctrl_readback", v, 32'h2);

        // Unselected access has no effect
        rd = 1; wr = 1; addr = 2'd0; wdata = 32'hFF;
        tick();
        rd = 0; wr = 0; wdata = 32'h0;
        bus_read(2'd3, v); chk("unselected_level", v, 32'h0);

        // Asynchronous reset mid-transfer
        bus_write(2'd0, 32'h77); bus_write(2'd0, 32'h78);
        out_valid = 1; out_data = 8'h99;
        #2 rstn = 0;
        #1;
        chk("arst_in_valid", 32'(in_valid), 32'h0);
        chk("arst_in_data", 32'(in_data), 32'h0);
        chk("arst_out_ready", 32'(out_ready), 32'h1);
        chk("arst_irqs", {30'h0, rx_irq, tx_irq}, 32'h0);
        out_valid = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fifo_mmio_bridge.md
# fifo_mmio_bridge

Parametrised memory-mapped bridge between the CPU data bus and a byte/word stream endpoint such as USB_CDC. It provides two independent buffered FIFOs: TX (CPU → `in_*` stream) and RX (`out_*` stream → CPU). It adds status, fill-level and control registers, sticky error flags and threshold interrupts. It sits on the CPU's MMIO decode alongside data memory and is the next-generation replacement for the fixed-size USB FIFO interface.

## Interface
- `DATA_W`, 8, stream data width in bits, 1..32.
- `TX_DEPTH`, 16, TX FIFO entries, power of two, ≥2.
- `RX_DEPTH`, 16, RX FIFO entries, power of two, ≥2.
- `clk_i`  in  1  single clock.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `sel_i`  in  1  bridge selected by bus decode this cycle.
- `read_i`  in  1  bus read; only meaningful with `sel_i`.
- `write_i`  in  1  bus write; only meaningful with `sel_i`.
- `addr_i`  in  2  register index.
- `data_i`  in  32  bus write data.
- `data_o`  out  32  bus read data; combinational.
- `rx_irq_o`  out  1  RX threshold interrupt; registered.
- `tx_irq_o`  out  1  TX empty interrupt; registered.
- `in_data_o`  out  DATA_W  TX head to the stream sink.
- `in_valid_o`  out  1  TX not empty.
- `in_ready_i`  in  1  sink accepts.
- `out_data_i`  in  DATA_W  stream source data.
- `out_valid_i`  in  1  source valid.
- `out_ready_o`  out  1  RX not full.

## Operation
- Register map, indexed by `addr_i`:
  - 0 DATA
    - Read returns the RX head, zero-extended, and pops it.
    - A read with RX empty returns 0, performs no pop and sets sticky `rx_underrun`.
    - A write pushes `data_i[DATA_W-1:0]` to TX.
    - A write with TX full is dropped and sets sticky `tx_overflow`.
  - 1 STATUS
    - Bits: [0] `rx_empty`, [1] `rx_full`, [2] `tx_empty`, [3] `tx_full`, [4] `rx_underrun`, [5] `tx_overflow`; other bits read 0.
    - Writing 1 to bit 4 or bit 5 clears that flag; all other bits are read-only.
  - 2 CTRL
    - Bits: [0] `rx_irq_en`, [1] `tx_irq_en`, [2] `rx_flush`, [3] `tx_flush`, [15:8] `rx_thresh`.
    - Bits 2 and 3 are self-clearing and always read 0.
  - 3 LEVEL: [15:0] `rx_count`, [31:16] `tx_count`; read-only.
- Bus rules:
  - Without `sel_i` there are no side effects, and `data_o` is don't-care but must not be X.
  - `read_i` and `write_i` together at DATA: pop RX and push TX, both allowed.
- Stream ports:
  - TX head is fall-through: `in_data_o` = oldest entry whenever `in_valid_o`=1.
  - TX pops on `in_valid_o & in_ready_i`.
  - RX pushes on `out_valid_i & out_ready_o`, with `out_ready_o` = `!rx_full`.
- Counts are `$clog2(DEPTH)+1` bits and are reported zero-extended.
- Pointers wrap modulo DEPTH.
- Interrupts:
  - `rx_irq_o` <= `rx_irq_en & (rx_count >= max(rx_thresh,1))`.
  - `tx_irq_o` <= `tx_irq_en & tx_empty`.
- Flush: `rx_flush` / `tx_flush` zero that FIFO's pointers and count at the write edge. Sticky flags are unaffected.

## Timing
- Reset values:
  - All counts and pointers 0; CTRL 0; sticky flags 0.
  - `rx_irq_o`=0, `tx_irq_o`=0, `in_valid_o`=0, `out_ready_o`=1, `in_data_o`=0.
- FIFO storage contents are not reset.
- Bus read data for the current cycle is combinational. Pop, push and register updates take effect at the next rising edge.
- A push into an empty TX makes `in_valid_o`=1 one cycle after the write.
- Interrupts lag the causing count change by one cycle.
- Simultaneous push and pop on one FIFO: count is unchanged, both succeed.
  - If TX is full, the CPU push is still dropped even when the stream pops in the same cycle, because the full flag uses current state.
  - If RX is empty, a CPU read still underruns even when the stream pushes in the same cycle.
- Flush in the same cycle as a push or pop on that FIFO: flush wins, and the push or pop is discarded.
- Asserting `rstn_i` mid-transfer aborts immediately, and all outputs take their reset values asynchronously.

## Structure
- Package `fifo_pkg`: register index constants, STATUS and CTRL bit-position constants, and the CTRL field layout.
- Sub-module `sync_fifo` (params `WIDTH`, `DEPTH`): push, pop, flush, fall-through head, count, full and empty.
  - Instantiated twice: once for TX, once for RX.
  - The bridge holds the decode, CTRL register, sticky flags and IRQ registers.

## Test plan
- Reset, then read STATUS → 0x5 (both FIFOs empty); `out_ready_o`=1, `in_valid_o`=0.
- Write 0xA1, 0xB2, 0xC3 to DATA with `in_ready_i`=0 → LEVEL[31:16]=3. Then raise `in_ready_i` → stream emits A1, B2, C3 on consecutive cycles, then `in_valid_o`=0.
- Stream-push RX_DEPTH bytes → `out_ready_o`=0 and STATUS bit1=1. One DATA read returns the first byte and `out_ready_o` returns to 1 the next cycle.
- Write 17 bytes into TX_DEPTH=16 with `in_ready_i`=0 → last byte dropped, STATUS bit5=1. Write STATUS 0x20 → bit5 cleared.
- Set CTRL = 0x0401 (`rx_thresh`=4, `rx_irq_en`=1); push 3 bytes → `rx_irq_o`=0; push a 4th → `rx_irq_o`=1 one cycle later; read one byte → `rx_irq_o`=0.
- Fill TX with 5 entries, write CTRL `tx_flush` in the same cycle the sink pops → `tx_count`=0, `in_valid_o`=0, `tx_irq_o`=1 if enabled; read DATA with RX empty → 0 and STATUS bit4=1.
